// File: rtl/cyc_pkg.sv
// cyc_pkg: shared types and elaboration-time unit-circle point generator for cyc_seq_gen.
package cyc_pkg;
  localparam int DEF_N_POINTS = 24;
  localparam int DEF_DATA_W = 16;
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  function automatic longint cyc_fix(input longint v, input int w);
    longint lim, r;
    lim = 64'sd1 <<< (w - 1);
    r = (v * lim + (64'sd1 <<< 29)) >>> 30;
    return r > lim - 1 ? lim - 1 : r < -lim ? -lim : r;
  endfunction
  // Returns {re[31:0], im[31:0]}; Taylor series in Q30 on the first quadrant, then rotated.
  function automatic logic [63:0] cyc_point(input int k, input int n, input int w);
    longint x, ts, tc, s, c, re, im;
    int q, r;
    q = (4 * k) / n;
    r = k - q * (n / 4);
    x = (2 * 64'sd3373259426 * r) / n;
    s = x;
    ts = x;
    c = 64'sd1 <<< 30;
    tc = c;
    for (int i = 1; i < 14; i++) begin
      ts = -((((ts * x) >>> 30) * x) >>> 30) / ((2 * i) * (2 * i + 1));
      tc = -((((tc * x) >>> 30) * x) >>> 30) / ((2 * i - 1) * (2 * i));
      s += ts;
      c += tc;
    end
    re = q == 0 ? c : q == 1 ? -s : q == 2 ? -c : s;
    im = q == 0 ? s : q == 1 ? c : q == 2 ? -s : -c;
    re = cyc_fix(re, w);
    im = cyc_fix(im, w);
    return {re[31:0], im[31:0]};
  endfunction
endpackage

// File: rtl/cyc_rom.sv
// cyc_rom: combinational index -> unit-circle point lookup, table fixed at elaboration.
module cyc_rom import cyc_pkg::*; #(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int DATA_W = DEF_DATA_W,
  localparam int IDX_W = $clog2(N_POINTS)
) (
  input  logic [IDX_W-1:0]         idx,
  output logic signed [DATA_W-1:0] re,
  output logic signed [DATA_W-1:0] im
);
  logic signed [DATA_W-1:0] tab_re [N_POINTS];
  logic signed [DATA_W-1:0] tab_im [N_POINTS];
  for (genvar k = 0; k < N_POINTS; k++) begin : g_tab
    localparam logic [63:0] P = cyc_point(k, N_POINTS, DATA_W);
    assign tab_re[k] = P[32 +: DATA_W];
    assign tab_im[k] = P[0 +: DATA_W];
  end
  assign re = tab_re[idx];
  assign im = tab_im[idx];
endmodule

// File: rtl/cyc_seq_gen.sv
// cyc_seq_gen: streams phasors e^{j2pi(p0+step*n)/N} with valid/ready; CYC_SEQ_GEN_CONJ_EN adds i_conj.
module cyc_seq_gen import cyc_pkg::*; #(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = 12,
  localparam int IDX_W = $clog2(N_POINTS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [IDX_W-1:0]         i_init_phase,
  input  logic [IDX_W-1:0]         i_step,
  input  logic [LEN_W-1:0]         i_len,
`ifdef CYC_SEQ_GEN_CONJ_EN
  input  logic                     i_conj,
`endif
  output logic                     o_idle,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_re,
  output logic signed [DATA_W-1:0] o_im,
  output logic                     o_last,
  output logic                     o_done
);
  localparam logic [IDX_W:0] NP = (IDX_W + 1)'(N_POINTS);
  localparam logic [IDX_W-1:0] NI = IDX_W'(N_POINTS);
  state_t state, state_nx;
  logic [IDX_W-1:0] acc, step, acc_nx;
  logic [IDX_W:0] sum;
  logic [LEN_W-1:0] len, cnt;
  logic accept, load, hs_last;
  logic signed [DATA_W-1:0] rom_re, rom_im, im_sel;
  cyc_rom #(.N_POINTS(N_POINTS), .DATA_W(DATA_W)) u_rom (.idx(acc), .re(rom_re), .im(rom_im));
  assign o_idle = state == S_IDLE;
  assign accept = o_idle && i_start && i_len != '0;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, step};
    acc_nx = sum >= NP ? IDX_W'(sum - NP) : sum[IDX_W-1:0];
    load = state == S_RUN && cnt != len && (!o_valid || i_ready);
    hs_last = o_valid && i_ready && o_last;
    state_nx = state == S_IDLE ? (accept ? S_RUN : S_IDLE) : (hs_last ? S_IDLE : S_RUN);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else state <= state_nx;
  end
`ifdef CYC_SEQ_GEN_CONJ_EN
  logic conj;
  localparam logic signed [DATA_W-1:0] MIN = {1'b1, {(DATA_W - 1){1'b0}}};
  always_ff @(posedge i_clk) begin
    if (i_rst) conj <= 1'b0;
    else if (accept) conj <= i_conj;
  end
  assign im_sel = !conj ? rom_im : rom_im == MIN ? ~MIN : -rom_im;
`else
  assign im_sel = rom_im;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc <= '0;
      step <= '0;
      len <= '0;
      cnt <= '0;
      o_valid <= 1'b0;
      o_last <= 1'b0;
      o_done <= 1'b0;
      o_re <= '0;
      o_im <= '0;
    end else begin
      o_done <= (o_idle && i_start && i_len == '0) || hs_last;
      if (accept) begin
        acc <= i_init_phase >= NI ? i_init_phase - NI : i_init_phase;
        step <= i_step >= NI ? i_step - NI : i_step;
        len <= i_len;
        cnt <= '0;
      end else if (load) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        o_valid <= 1'b1;
        o_re <= rom_re;
        o_im <= im_sel;
        o_last <= cnt == len - 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cyc_seq_gen.sv
// tb_cyc_seq_gen: scoreboard bench; expected beats come from a real-valued cos/sin model.
module tb_cyc_seq_gen;
  import cyc_pkg::*;
  localparam int N = 24, W = 16, LW = 12, IW = 5;
`ifdef CYC_SEQ_GEN_CONJ_EN
  localparam bit CONJ_EN = 1'b1;
`else
  localparam bit CONJ_EN = 1'b0;
`endif
  typedef struct packed {
    cplx_t c;
    logic  last;
  } beat_t;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_ready = 1;
  logic [IW-1:0] i_init_phase = '0, i_step = '0;
  logic [LW-1:0] i_len = '0;
  logic o_idle, o_valid, o_last, o_done;
  logic signed [W-1:0] o_re, o_im;
`ifdef CYC_SEQ_GEN_CONJ_EN
  logic i_conj = 0;
`endif
  cyc_seq_gen dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_init_phase(i_init_phase),
    .i_step(i_step), .i_len(i_len),
`ifdef CYC_SEQ_GEN_CONJ_EN
    .i_conj(i_conj),
`endif
    .o_idle(o_idle), .o_valid(o_valid), .i_ready(i_ready), .o_re(o_re), .o_im(o_im),
    .o_last(o_last), .o_done(o_done)
  );
  always #5 i_clk = ~i_clk;
  beat_t exp_q[$], rx[$], prev_b;
  int n_tests = 0, n_fail = 0, done_seen = 0, done_exp = 0, hs_cnt = 0, rdy_mode = 0;
  bit prev_stall = 0, prev_hs_last = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > (1 << (W - 1)) - 1 ? (1 << (W - 1)) - 1 : v < -(1 << (W - 1)) ? -(1 << (W - 1)) : v;
  endfunction
  function automatic beat_t model(input int k, input bit cj, input bit last);
    real a, sc;
    int re, im;
    beat_t b;
    sc = real'(1 << (W - 1));
    a = 2.0 * 3.141592653589793 * k / N;
    re = sat(int'($floor($cos(a) * sc + 0.5)));
    im = sat(int'($floor($sin(a) * sc + 0.5)));
    if (cj) im = sat(-im);
    b.c.re = re[W-1:0];
    b.c.im = im[W-1:0];
    b.last = last;
    return b;
  endfunction
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 0;
      prev_hs_last = 0;
    end else begin
      if (prev_stall) chk("hold_stall", {o_valid, o_re, o_im, o_last}, {1'b1, prev_b});
      if (prev_hs_last) chk("done_after_last", {o_done, o_idle, o_valid}, 3'b110);
      if (o_done) done_seen++;
      if (o_valid && i_ready) begin
        hs_cnt++;
        rx.push_back({o_re, o_im, o_last});
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", {o_re, o_im, o_last});
        end else chk("beat", {o_re, o_im, o_last}, exp_q.pop_front());
      end
      prev_stall = o_valid && !i_ready;
      prev_b = {o_re, o_im, o_last};
      prev_hs_last = o_valid && i_ready && o_last;
    end
  end
  initial begin
    int ph = 0;
    forever begin
      @(posedge i_clk);
      #1;
      ph++;
      i_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom);
    end
  end
  task automatic cmd(input int p0, input int st, input int ln, input bit cj);
    int t = 0;
    while (!o_idle && t < 1000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    if (t >= 1000) chk("idle_timeout", 0, 1);
    i_start = 1;
    i_init_phase = IW'(p0);
    i_step = IW'(st);
    i_len = LW'(ln);
`ifdef CYC_SEQ_GEN_CONJ_EN
    i_conj = cj;
`endif
    for (int n = 0; n < ln; n++) exp_q.push_back(model((p0 + st * n) % N, cj & CONJ_EN, n == ln - 1));
    done_exp++;
    @(posedge i_clk);
    #1;
    i_start = 0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (done_seen < done_exp && t < 3000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    chk("done_count", done_seen, done_exp);
    chk("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    int base, t;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_state", {o_idle, o_valid, o_last, o_done, o_re, o_im}, {4'b1000, 32'h0});
    i_rst = 0;
    rx.delete();
    cmd(0, 1, 24, 0);
    wait_done();
    chk("full_len", rx.size(), 24);
    chk("full_b1", rx[1], {16'h7BA3, 16'h2121, 1'b0});
    chk("full_b6", rx[6], {16'h0000, 16'h7FFF, 1'b0});
    chk("full_b18", rx[18], {16'h0000, 16'h8000, 1'b0});
    chk("full_last", {rx[22].last, rx[23].last}, 2'b01);
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      rx.delete();
      cmd(21, 5, 4, 0);
      wait_done();
      chk("s21_len", rx.size(), 4);
      chk("s21_b0", rx[0], {16'h5A82, 16'hA57E, 1'b0});
      chk("s21_b1", rx[1], {16'h6EDA, 16'h4000, 1'b0});
      chk("s21_b2", rx[2], {16'hDEDF, 16'h7BA3, 1'b0});
      chk("s21_b3", rx[3], {16'h8000, 16'h0000, 1'b1});
    end
    rdy_mode = 0;
    cmd(3, 7, 8, 0);
    i_start = 1;
    i_init_phase = 5;
    i_step = 2;
    i_len = 3;
    repeat (2) @(posedge i_clk);
    #1;
    i_start = 0;
    wait_done();
    cmd(4, 1, 0, 0);
    wait_done();
    chk("len0_no_valid", o_valid, 0);
    cmd(2, 3, 10, 0);
    base = hs_cnt;
    t = 0;
    while (hs_cnt < base + 3 && t < 100) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    chk("rst_wait", hs_cnt >= base + 3, 1);
    i_rst = 1;
    @(posedge i_clk);
    #1;
    i_rst = 0;
    exp_q.delete();
    done_exp = done_seen;
    chk("mid_reset", {o_valid, o_idle, o_done}, 3'b010);
    rx.delete();
    cmd(6, 0, 2, 0);
    wait_done();
    chk("step0_b0", rx[0], {16'h0000, 16'h7FFF, 1'b0});
    chk("step0_b1", rx[1], {16'h0000, 16'h7FFF, 1'b1});
    rdy_mode = 2;
    for (int i = 0; i < 20; i++)
      cmd($urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(20, 1), 1'($urandom));
    wait_done();
    rdy_mode = 0;
`ifdef CYC_SEQ_GEN_CONJ_EN
    rx.delete();
    cmd(18, 0, 1, 1);
    cmd(3, 0, 1, 1);
    wait_done();
    chk("conj_sat", rx[0], {16'h0000, 16'h7FFF, 1'b1});
    chk("conj_45", rx[1], {16'h5A82, 16'hA57E, 1'b1});
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
